// File: rtl/prism_cfg_seq_if.sv
// prism_cfg_seq_if: host push channel and PRISM debug-write channel for the
// configuration sequencer. The master side is the host/environment and the
// slave side is the sequencer itself.
interface prism_cfg_seq_if;
    logic        push_valid;
    logic [5:0]  push_addr;
    logic [31:0] push_data;
    logic        push_ready;

    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_wr;
    logic [31:0] dbg_rdata;

    modport master (
        output push_valid, push_addr, push_data, dbg_rdata,
        input  push_ready, dbg_addr, dbg_wdata, dbg_wr
    );

    modport slave (
        input  push_valid, push_addr, push_data, dbg_rdata,
        output push_ready, dbg_addr, dbg_wdata, dbg_wr
    );
endinterface

// File: rtl/prism_cfg_seq.sv
// prism_cfg_seq: buffers {addr,data} config entries from a host, then on start
// resets PRISM, replays the entries over the debug write port (one write every
// three cycles), waits a settle period and enables PRISM. Raises a one-cycle
// interrupt on a halt rising edge while running.
// Optional feature: define PRISM_SEQ_READBACK_EN to verify each write via
// dbg_rdata; a mismatch sets the sticky err flag and aborts the load.
module prism_cfg_seq #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    prism_cfg_seq_if.slave  bus,
    input  logic            start,
    input  logic            stop,
    input  logic            halt,
    output logic            fsm_reset,
    output logic            fsm_enable,
    output logic            busy,
    output logic            halt_irq,
    output logic            err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(SETTLE_CYC + 2) + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    logic [37:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            push_fire;
    logic            have_entry;
    logic            pop_slot;
    logic            pop;
    logic            flush;
    logic            err_set;
    logic            err_clr;
    logic            mismatch;
    logic [37:0]     head;
    logic            halt_q;

`ifdef PRISM_SEQ_READBACK_EN
    assign mismatch = (bus.dbg_rdata != bus.dbg_wdata);
`else
    assign mismatch = 1'b0;
`endif

    assign full       = (count == FULL_CNT);
    // A pop slot frees a place in the same cycle, so a full FIFO can still take a push.
    assign pop_slot   = ((state == ST_RESET) && (cnt == CW'(1))) ||
                        ((state == ST_LOAD) && (cnt == CW'(2)) && !mismatch);
    assign bus.push_ready = !full || pop_slot;
    assign push_fire  = bus.push_valid && bus.push_ready;
    // An entry arriving at the pop slot of an empty FIFO is bypassed straight out.
    assign have_entry = (count != '0) || push_fire;
    assign pop        = pop_slot && have_entry;
    assign head       = (count == '0) ? {bus.push_addr, bus.push_data} : mem[rd_ptr];
    assign bus.dbg_wr = (state == ST_LOAD) && (cnt == '0);

    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, phase counter and control outputs
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        flush      = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        fsm_reset  = 1'b0;
        fsm_enable = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                    err_clr  = 1'b1;
                end
            end
            ST_RESET: begin
                fsm_reset = 1'b1;
                busy      = 1'b1;
                if (pop_slot) begin
                    state_nx = have_entry ? ST_LOAD : ST_SETTLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_LOAD: begin
                fsm_reset = 1'b1;
                busy      = 1'b1;
                if (cnt == CW'(2)) begin
                    cnt_nx = '0;
                    if (mismatch) begin
                        state_nx = ST_IDLE;
                        flush    = 1'b1;
                        err_set  = 1'b1;
                    end else if (!have_entry) begin
                        state_nx = ST_SETTLE;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt == CW'(SETTLE_CYC - 1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                fsm_enable = 1'b1;
                if (start) begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                    err_clr  = 1'b1;
                end else if (stop) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // FIFO storage (no reset needed, validity tracked by count)
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= {bus.push_addr, bus.push_data};
        end
    end

    // FIFO pointers and occupancy; an aborted load drops everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            case ({push_fire, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Debug write address/data, held stable through the gap cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dbg_addr  <= '0;
            bus.dbg_wdata <= '0;
        end else if (pop) begin
            bus.dbg_addr  <= head[37:32];
            bus.dbg_wdata <= head[31:0];
        end
    end

    // Halt edge detect, interrupt only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q   <= 1'b0;
            halt_irq <= 1'b0;
        end else begin
            halt_q   <= halt;
            halt_irq <= (state == ST_RUN) && halt && !halt_q;
        end
    end

`ifdef PRISM_SEQ_READBACK_EN
    // Sticky readback error, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    logic rb_unused;
    assign rb_unused = err_set | err_clr | (^bus.dbg_rdata);
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_prism_cfg_seq.sv
// tb_prism_cfg_seq: directed test of the config sequencer (DEPTH=4,
// SETTLE_CYC=2) with hand-computed expected timelines. The readback section
// is active when PRISM_SEQ_READBACK_EN is defined.
module tb_prism_cfg_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic halt  = 1'b0;
    logic fsm_reset, fsm_enable, busy, halt_irq, err;

    logic        rb_force = 1'b0;
    logic [31:0] rb_val   = 32'hDEAD_BEEF;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    prism_cfg_seq_if bus ();

    // Debug memory model: reads back what was written unless forced
    always_comb bus.dbg_rdata = rb_force ? rb_val : bus.dbg_wdata;

    prism_cfg_seq #(
        .DEPTH      (4),
        .SETTLE_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .start      (start),
        .stop       (stop),
        .halt       (halt),
        .fsm_reset  (fsm_reset),
        .fsm_enable (fsm_enable),
        .busy       (busy),
        .halt_irq   (halt_irq),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_now(input logic [5:0] a, input logic [31:0] d);
        check("push_ready_before_push", 32'(bus.push_ready), 32'd1);
        bus.push_valid = 1'b1;
        bus.push_addr  = a;
        bus.push_data  = d;
        tick();
        bus.push_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_dbg_wr"},     32'(bus.dbg_wr),     32'd0);
        check({pfx, "_dbg_addr"},   32'(bus.dbg_addr),   32'd0);
        check({pfx, "_dbg_wdata"},  bus.dbg_wdata,       32'd0);
        check({pfx, "_fsm_reset"},  32'(fsm_reset),      32'd0);
        check({pfx, "_fsm_enable"}, 32'(fsm_enable),     32'd0);
        check({pfx, "_busy"},       32'(busy),           32'd0);
        check({pfx, "_halt_irq"},   32'(halt_irq),       32'd0);
        check({pfx, "_err"},        32'(err),            32'd0);
        check({pfx, "_push_ready"}, 32'(bus.push_ready), 32'd1);
    endtask

    // Watchdog: the bench must never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] exp_rst;
        logic [10:0] exp_wr;
        logic [10:0] exp_en;
        logic [5:0]  wa [8];
        logic [31:0] wd [8];
        int unsigned nwr;
        int unsigned irq_cnt;

        bus.push_valid = 1'b0;
        bus.push_addr  = '0;
        bus.push_data  = '0;

        // Reset state
        repeat (2) tick();
        check_reset_vals("por");
        rst_n = 1'b1;
        tick();

        // Two-entry load: RESET x2, writes at +2 and +5, RUN at +10
        push_now(6'h00, 32'h2000_0001);
        push_now(6'h20, 32'h0000_0010);
        pulse_start();
        exp_rst = 11'b000_1111_1111;
        exp_wr  = 11'b000_0010_0100;
        exp_en  = 11'b100_0000_0000;
        for (int k = 0; k < 11; k++) begin
            check($sformatf("load2_rst_k%0d", k), 32'(fsm_reset),  32'(exp_rst[k]));
            check($sformatf("load2_wr_k%0d", k),  32'(bus.dbg_wr), 32'(exp_wr[k]));
            check($sformatf("load2_en_k%0d", k),  32'(fsm_enable), 32'(exp_en[k]));
            if (k == 2) check("load2_addr0", 32'(bus.dbg_addr), 32'h00);
            if (k >= 2 && k <= 4) check($sformatf("load2_data0_k%0d", k), bus.dbg_wdata, 32'h2000_0001);
            if (k == 5) check("load2_addr1", 32'(bus.dbg_addr), 32'h20);
            if (k >= 5 && k <= 7) check($sformatf("load2_data1_k%0d", k), bus.dbg_wdata, 32'h0000_0010);
            tick();
        end

        // Halt rising edge in RUN gives exactly one interrupt pulse
        halt = 1'b1;
        irq_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            irq_cnt += 32'(halt_irq);
        end
        check("halt_irq_pulses", irq_cnt, 32'd1);
        check("halt_keeps_run", 32'(fsm_enable), 32'd1);
        halt = 1'b0;

        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_enable", 32'(fsm_enable), 32'd0);
        check("stop_busy",   32'(busy),       32'd0);

        // Empty start: RESET x2, SETTLE x2, RUN at +4, no writes
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("empty_wr_k%0d", k),  32'(bus.dbg_wr), 32'd0);
            check($sformatf("empty_rst_k%0d", k), 32'(fsm_reset),  32'(k < 2));
            check($sformatf("empty_en_k%0d", k),  32'(fsm_enable), 32'(k == 4));
            tick();
        end

        // start and stop together in RUN: start wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_rst", 32'(fsm_reset),  32'd1);
        check("startstop_en",  32'(fsm_enable), 32'd0);
        repeat (4) tick();
        check("startstop_run", 32'(fsm_enable), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Overfill: 4 entries fill the FIFO, the 5th enters on the first pop
        for (int i = 0; i < 4; i++) push_now(6'(i), 32'h100 + 32'(i));
        check("full_ready", 32'(bus.push_ready), 32'd0);
        bus.push_valid = 1'b1;
        bus.push_addr  = 6'd4;
        bus.push_data  = 32'h104;
        pulse_start();
        check("full_ready_reset0", 32'(bus.push_ready), 32'd0);
        tick();
        check("full_ready_popslot", 32'(bus.push_ready), 32'd1);
        tick();
        bus.push_valid = 1'b0;
        nwr = 0;
        for (int c = 0; c < 40 && !fsm_enable; c++) begin
            if (bus.dbg_wr && nwr < 8) begin
                wa[nwr] = bus.dbg_addr;
                wd[nwr] = bus.dbg_wdata;
                nwr++;
            end
            tick();
        end
        check("full_run_reached", 32'(fsm_enable), 32'd1);
        check("full_nwrites", nwr, 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < int'(nwr)) begin
                check($sformatf("full_addr%0d", i), 32'(wa[i]), 32'(i));
                check($sformatf("full_data%0d", i), wd[i], 32'h100 + 32'(i));
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Asynchronous reset during the second write of a load
        push_now(6'h03, 32'h0000_000A);
        push_now(6'h04, 32'h0000_000B);
        push_now(6'h05, 32'h0000_000C);
        pulse_start();
        repeat (5) tick();
        check("midload_wr",   32'(bus.dbg_wr), 32'd1);
        check("midload_data", bus.dbg_wdata,   32'h0000_000B);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("postrst_wr_k%0d", k), 32'(bus.dbg_wr), 32'd0);
            check($sformatf("postrst_en_k%0d", k), 32'(fsm_enable), 32'(k == 4));
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

`ifdef PRISM_SEQ_READBACK_EN
        // Readback mismatch aborts the load, drops entries, sets err
        push_now(6'h01, 32'h0000_0001);
        push_now(6'h02, 32'h0000_0002);
        rb_force = 1'b1;
        pulse_start();
        repeat (2) tick();
        check("rb_wr0",   32'(bus.dbg_wr), 32'd1);
        check("rb_data0", bus.dbg_wdata,   32'h0000_0001);
        repeat (3) tick();
        check("rb_err",      32'(err),       32'd1);
        check("rb_idle",     32'(busy),      32'd0);
        check("rb_rst_low",  32'(fsm_reset), 32'd0);
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            nwr += 32'(bus.dbg_wr);
            tick();
        end
        check("rb_no_more_writes", nwr, 32'd0);
        rb_force = 1'b0;
        pulse_start();
        check("rb_err_cleared", 32'(err), 32'd0);
        nwr = 0;
        for (int c = 0; c < 4; c++) begin
            nwr += 32'(bus.dbg_wr);
            tick();
        end
        check("rb_dropped", nwr, 32'd0);
        check("rb_run", 32'(fsm_enable), 32'd1);
`else
        check("err_tied", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
